// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage -- execute stage of a single-issue pipeline.
//
// Computes the ALU result, resolves branches and jumps, and registers the
// outcome for the next stage. A taken branch or jump that is sitting in the
// output register kills the instruction arriving behind it, because that
// instruction was fetched from the wrong path.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   id_valid            instruction present from decode
//   id_alucontrol[3:0]  ALU operation (ALUOP_* in ex_stage_pkg)
//   id_inv_branch       invert branch condition (bne/bge/bgeu)
//   id_is_branch/_jal/_jalr  instruction class, mutually exclusive
//   id_src_a/_b[31:0]   forwarded ALU operands
//   id_pc/_imm[31:0]    instruction PC, sign-extended immediate
//   id_rd[4:0], id_reg_write  destination register and write enable
//   stall, flush        hold the stage / insert a bubble (flush wins)
//   ex_*                registered results; all zero while in a bubble
// ---------------------------------------------------------------------------
package ex_stage_pkg;

   localparam logic [3:0] ALUOP_ADD  = 4'd0;
   localparam logic [3:0] ALUOP_SUB  = 4'd1;
   localparam logic [3:0] ALUOP_SLL  = 4'd2;
   localparam logic [3:0] ALUOP_SLT  = 4'd3;
   localparam logic [3:0] ALUOP_SLTU = 4'd4;
   localparam logic [3:0] ALUOP_XOR  = 4'd5;
   localparam logic [3:0] ALUOP_SRL  = 4'd6;
   localparam logic [3:0] ALUOP_SRA  = 4'd7;
   localparam logic [3:0] ALUOP_OR   = 4'd8;
   localparam logic [3:0] ALUOP_AND  = 4'd9;

   // Everything the stage registers; an all-zero value is a bubble.
   typedef struct packed {
      logic        valid;
      logic [31:0] result;
      logic [4:0]  rd;
      logic        reg_write;
      logic        branch_taken;
      logic [31:0] branch_target;
      logic        illegal_op;
   } ex_out_t;

   localparam ex_out_t EX_BUBBLE = '0;

endpackage

module ex_stage
   import ex_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        id_valid,
   input  logic [3:0]  id_alucontrol,
   input  logic        id_inv_branch,
   input  logic        id_is_branch,
   input  logic        id_is_jal,
   input  logic        id_is_jalr,
   input  logic [31:0] id_src_a,
   input  logic [31:0] id_src_b,
   input  logic [31:0] id_pc,
   input  logic [31:0] id_imm,
   input  logic [4:0]  id_rd,
   input  logic        id_reg_write,
   input  logic        stall,
   input  logic        flush,
   output logic        ex_valid,
   output logic [31:0] ex_result,
   output logic [4:0]  ex_rd,
   output logic        ex_reg_write,
   output logic        ex_branch_taken,
   output logic [31:0] ex_branch_target,
   output logic        ex_illegal_op
);

   ex_out_t     out_q, out_d;
   logic [31:0] alu_res;
   logic        alu_ok;
   logic        br_cond;
   logic        squash;
   logic [31:0] pc_plus_imm;
   logic [31:0] pc_plus_4;
   logic [31:0] jalr_target;

   // All adders wrap modulo 2^32; no overflow is reported.
   assign pc_plus_imm = id_pc + id_imm;
   assign pc_plus_4   = id_pc + 32'd4;
   assign jalr_target = (id_src_a + id_imm) & 32'hFFFF_FFFE;

   // -------------------------------------------------------------- ALU
   always_comb begin
      // NOTE: every signal assigned in a combinational block gets a default
      // first, so no path through the case can leave it unassigned (latch).
      alu_res = '0;
      alu_ok  = 1'b1;
      case (id_alucontrol)
         ALUOP_ADD:  alu_res = id_src_a + id_src_b;
         ALUOP_SUB:  alu_res = id_src_a - id_src_b;
         ALUOP_SLL:  alu_res = id_src_a << id_src_b[4:0];
         ALUOP_SLT:  alu_res = {31'd0, $signed(id_src_a) < $signed(id_src_b)};
         ALUOP_SLTU: alu_res = {31'd0, id_src_a < id_src_b};
         ALUOP_XOR:  alu_res = id_src_a ^ id_src_b;
         ALUOP_SRL:  alu_res = id_src_a >> id_src_b[4:0];
         ALUOP_SRA:  alu_res = 32'($signed(id_src_a) >>> id_src_b[4:0]);
         ALUOP_OR:   alu_res = id_src_a | id_src_b;
         ALUOP_AND:  alu_res = id_src_a & id_src_b;
         default:    alu_ok  = 1'b0;
      endcase
   end

   // beq/bne compare via SUB == 0; blt/bge/bltu/bgeu use bit 0 of SLT/SLTU.
   assign br_cond = (id_alucontrol == ALUOP_SUB) ? (alu_res == 32'd0) : alu_res[0];

   // Wrong-path kill: a registered taken branch/jump discards whatever decode
   // presents on the next unstalled edge. The bubble it loads clears
   // branch_taken, so the kill lasts exactly one accepted slot.
   assign squash = out_q.valid & out_q.branch_taken;

   // ------------------------------------------------------- next state
   always_comb begin
      out_d = out_q;
      if (flush) begin
         out_d = EX_BUBBLE;
      end else if (stall) begin
         out_d = out_q;
      end else if (squash || !id_valid) begin
         out_d = EX_BUBBLE;
      end else begin
         out_d       = EX_BUBBLE;
         out_d.valid = 1'b1;
         out_d.rd    = id_rd;   // rd=0 passes through; writeback ignores x0
         if (id_is_jal || id_is_jalr) begin
            out_d.result        = pc_plus_4;
            out_d.reg_write     = id_reg_write;
            out_d.branch_taken  = 1'b1;
            out_d.branch_target = id_is_jal ? pc_plus_imm : jalr_target;
         end else if (id_is_branch) begin
            out_d.branch_taken  = alu_ok & (br_cond ^ id_inv_branch);
            out_d.branch_target = pc_plus_imm;
            out_d.illegal_op    = ~alu_ok;
         end else begin
            out_d.result        = alu_ok ? alu_res : 32'd0;
            out_d.reg_write     = id_reg_write & alu_ok;
            out_d.illegal_op    = ~alu_ok;
         end
      end
   end

   // ----------------------------------------------------------- state
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the output register is reset asynchronously so the stage shows
      // a bubble the moment rst_n falls; there is no memory here to leave
      // unreset.
      if (!rst_n) out_q <= EX_BUBBLE;
      else        out_q <= out_d;
   end

   assign ex_valid         = out_q.valid;
   assign ex_result        = out_q.result;
   assign ex_rd            = out_q.rd;
   assign ex_reg_write     = out_q.reg_write;
   assign ex_branch_taken  = out_q.branch_taken;
   assign ex_branch_target = out_q.branch_target;
   assign ex_illegal_op    = out_q.illegal_op;

endmodule

// File: tb/tb_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_stage -- directed self-checking bench for ex_stage.
// Expected values are hand-computed constants packed in output order:
// {valid, result, rd, reg_write, taken, target, illegal}.
// ---------------------------------------------------------------------------
module tb_ex_stage;
   import ex_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid, id_inv_branch, id_is_branch, id_is_jal, id_is_jalr;
   logic [3:0]  id_alucontrol;
   logic [31:0] id_src_a, id_src_b, id_pc, id_imm;
   logic [4:0]  id_rd;
   logic        id_reg_write, stall, flush;
   logic        ex_valid, ex_reg_write, ex_branch_taken, ex_illegal_op;
   logic [31:0] ex_result, ex_branch_target;
   logic [4:0]  ex_rd;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   ex_stage dut (
      .clk(clk), .rst_n(rst_n),
      .id_valid(id_valid), .id_alucontrol(id_alucontrol),
      .id_inv_branch(id_inv_branch), .id_is_branch(id_is_branch),
      .id_is_jal(id_is_jal), .id_is_jalr(id_is_jalr),
      .id_src_a(id_src_a), .id_src_b(id_src_b),
      .id_pc(id_pc), .id_imm(id_imm),
      .id_rd(id_rd), .id_reg_write(id_reg_write),
      .stall(stall), .flush(flush),
      .ex_valid(ex_valid), .ex_result(ex_result), .ex_rd(ex_rd),
      .ex_reg_write(ex_reg_write), .ex_branch_taken(ex_branch_taken),
      .ex_branch_target(ex_branch_target), .ex_illegal_op(ex_illegal_op)
   );

   localparam logic [72:0] BUBBLE = '0;

   function automatic logic [72:0] obs();
      return {ex_valid, ex_result, ex_rd, ex_reg_write,
              ex_branch_taken, ex_branch_target, ex_illegal_op};
   endfunction

   function automatic logic [72:0] ex(input logic v, input logic [31:0] res,
                                      input logic [4:0] rd, input logic rw,
                                      input logic tk, input logic [31:0] tgt,
                                      input logic ill);
      return {v, res, rd, rw, tk, tgt, ill};
   endfunction

   // Generic instruction drive; class flags: 0 alu, 1 branch, 2 jal, 3 jalr.
   task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] pc,
                        input logic [31:0] imm, input logic [4:0] rd,
                        input logic rw, input int cls, input logic inv);
      id_valid      = v;
      id_alucontrol = op;
      id_src_a      = a;
      id_src_b      = b;
      id_pc         = pc;
      id_imm        = imm;
      id_rd         = rd;
      id_reg_write  = rw;
      id_is_branch  = (cls == 1);
      id_is_jal     = (cls == 2);
      id_is_jalr    = (cls == 3);
      id_inv_branch = inv;
   endtask

   task automatic alu(input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] rd);
      drive(1'b1, op, a, b, 32'd0, 32'd0, rd, 1'b1, 0, 1'b0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
      drive(1'b1, ALUOP_ADD, 32'd1, 32'd1, 32'd0, 32'd0, 5'd1, 1'b1, 0, 1'b0);
      #3;
      total++;
      if (obs() !== BUBBLE) $display("FAIL reset_state got %h exp %h", obs(), BUBBLE);
      else passed++;
      #9 rst_n = 1'b1;   // t=12, away from any edge
   endtask

   task automatic test_alu();
      alu(ALUOP_ADD, 32'd5, 32'd7, 5'd3); tick();
      total++;
      if (obs() !== ex(1, 32'd12, 5'd3, 1, 0, 0, 0))
         $display("FAIL add_5_7 got %h exp %h", obs(), ex(1, 32'd12, 5'd3, 1, 0, 0, 0));
      else passed++;

      alu(ALUOP_SUB, 32'd3, 32'd5, 5'd4); tick();
      total++;
      if (ex_result !== 32'hFFFF_FFFE) $display("FAIL sub_3_5 got %h exp fffffffe", ex_result);
      else passed++;

      alu(ALUOP_SRA, 32'h8000_0000, 32'd4, 5'd5); tick();
      total++;
      if (ex_result !== 32'hF800_0000) $display("FAIL sra got %h exp f8000000", ex_result);
      else passed++;

      alu(ALUOP_SRL, 32'h8000_0000, 32'd4, 5'd5); tick();
      total++;
      if (ex_result !== 32'h0800_0000) $display("FAIL srl got %h exp 08000000", ex_result);
      else passed++;

      alu(ALUOP_SLT, 32'hFFFF_FFFF, 32'd1, 5'd6); tick();
      total++;
      if (ex_result !== 32'd1) $display("FAIL slt got %h exp 1", ex_result);
      else passed++;

      alu(ALUOP_SLTU, 32'hFFFF_FFFF, 32'd1, 5'd6); tick();
      total++;
      if (ex_result !== 32'd0) $display("FAIL sltu got %h exp 0", ex_result);
      else passed++;

      // shift amount uses only b[4:0]: 33 -> 1
      alu(ALUOP_SLL, 32'h0000_0003, 32'd33, 5'd7); tick();
      total++;
      if (ex_result !== 32'd6) $display("FAIL sll_mask got %h exp 6", ex_result);
      else passed++;

      alu(ALUOP_XOR, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd8); tick();
      total++;
      if (ex_result !== 32'hFF00_0FF0) $display("FAIL xor got %h exp ff000ff0", ex_result);
      else passed++;

      alu(ALUOP_OR, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd8); tick();
      total++;
      if (ex_result !== 32'hFFF0_0FFF) $display("FAIL or got %h exp fff00fff", ex_result);
      else passed++;

      alu(ALUOP_AND, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd8); tick();
      total++;
      if (ex_result !== 32'h00F0_000F) $display("FAIL and got %h exp 00f0000f", ex_result);
      else passed++;

      // wrap, no overflow flag; rd=0 passes through with reg_write kept
      alu(ALUOP_ADD, 32'hFFFF_FFFF, 32'd2, 5'd0); tick();
      total++;
      if (obs() !== ex(1, 32'd1, 5'd0, 1, 0, 0, 0))
         $display("FAIL add_wrap_x0 got %h exp %h", obs(), ex(1, 32'd1, 5'd0, 1, 0, 0, 0));
      else passed++;

      drive(1'b1, 4'hF, 32'd9, 32'd9, 32'd0, 32'd0, 5'd9, 1'b1, 0, 1'b0); tick();
      total++;
      if (obs() !== ex(1, 32'd0, 5'd9, 0, 0, 0, 1))
         $display("FAIL illegal_op got %h exp %h", obs(), ex(1, 32'd0, 5'd9, 0, 0, 0, 1));
      else passed++;

      drive(1'b0, ALUOP_ADD, 32'd9, 32'd9, 32'd0, 32'd0, 5'd9, 1'b1, 0, 1'b0); tick();
      total++;
      if (obs() !== BUBBLE) $display("FAIL invalid_bubble got %h exp %h", obs(), BUBBLE);
      else passed++;
   endtask

   task automatic test_branch_squash();
      // bne not taken, target still reported
      drive(1'b1, ALUOP_SUB, 32'd3, 32'd3, 32'h100, 32'h10, 5'd1, 1'b0, 1, 1'b1); tick();
      total++;
      if (obs() !== ex(1, 32'd0, 5'd1, 0, 0, 32'h110, 0))
         $display("FAIL bne_not_taken got %h exp %h", obs(), ex(1, 32'd0, 5'd1, 0, 0, 32'h110, 0));
      else passed++;

      drive(1'b1, ALUOP_SUB, 32'd3, 32'd4, 32'h100, 32'h10, 5'd1, 1'b0, 1, 1'b1); tick();
      total++;
      if (obs() !== ex(1, 32'd0, 5'd1, 0, 1, 32'h110, 0))
         $display("FAIL bne_taken got %h exp %h", obs(), ex(1, 32'd0, 5'd1, 0, 1, 32'h110, 0));
      else passed++;

      alu(ALUOP_ADD, 32'd10, 32'd20, 5'd2); tick();
      total++;
      if (obs() !== BUBBLE) $display("FAIL shadow_squash got %h exp %h", obs(), BUBBLE);
      else passed++;

      // same ADD held on the bus: accepted now that the kill is spent
      tick();
      total++;
      if (obs() !== ex(1, 32'd30, 5'd2, 1, 0, 0, 0))
         $display("FAIL squash_one_shot got %h exp %h", obs(), ex(1, 32'd30, 5'd2, 1, 0, 0, 0));
      else passed++;

      // blt via SLT: -2 < 1 -> taken
      drive(1'b1, ALUOP_SLT, 32'hFFFF_FFFE, 32'd1, 32'h40, 32'hFFFF_FFF0, 5'd0, 1'b0, 1, 1'b0); tick();
      total++;
      if (obs() !== ex(1, 32'd0, 5'd0, 0, 1, 32'h30, 0))
         $display("FAIL blt_taken got %h exp %h", obs(), ex(1, 32'd0, 5'd0, 0, 1, 32'h30, 0));
      else passed++;
      drive(1'b0, ALUOP_ADD, 0, 0, 0, 0, 5'd0, 1'b0, 0, 1'b0); tick();
   endtask

   task automatic test_jumps();
      drive(1'b1, ALUOP_ADD, 32'h1001, 32'd0, 32'h200, 32'd4, 5'd1, 1'b1, 3, 1'b0); tick();
      total++;
      if (obs() !== ex(1, 32'h204, 5'd1, 1, 1, 32'h1004, 0))
         $display("FAIL jalr got %h exp %h", obs(), ex(1, 32'h204, 5'd1, 1, 1, 32'h1004, 0));
      else passed++;
      drive(1'b0, ALUOP_ADD, 0, 0, 0, 0, 5'd0, 1'b0, 0, 1'b0); tick();

      drive(1'b1, ALUOP_ADD, 32'd0, 32'd0, 32'h300, 32'h20, 5'd5, 1'b1, 2, 1'b0); tick();
      total++;
      if (obs() !== ex(1, 32'h304, 5'd5, 1, 1, 32'h320, 0))
         $display("FAIL jal got %h exp %h", obs(), ex(1, 32'h304, 5'd5, 1, 1, 32'h320, 0));
      else passed++;
      drive(1'b0, ALUOP_ADD, 0, 0, 0, 0, 5'd0, 1'b0, 0, 1'b0); tick();
   endtask

   task automatic test_stall_flush();
      // beq 7==7 taken
      drive(1'b1, ALUOP_SUB, 32'd7, 32'd7, 32'h40, 32'd8, 5'd0, 1'b0, 1, 1'b0); tick();
      alu(ALUOP_ADD, 32'd1, 32'd2, 5'd3);
      stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         total++;
         if (obs() !== ex(1, 32'd0, 5'd0, 0, 1, 32'h48, 0))
            $display("FAIL stall_hold_%0d got %h exp %h", i, obs(), ex(1, 32'd0, 5'd0, 0, 1, 32'h48, 0));
         else passed++;
      end
      stall = 1'b0; tick();
      total++;
      if (obs() !== BUBBLE) $display("FAIL squash_after_stall got %h exp %h", obs(), BUBBLE);
      else passed++;

      // ADD still on the bus is accepted; then stall+flush gives a bubble
      tick();
      total++;
      if (ex_result !== 32'd3) $display("FAIL post_squash_add got %h exp 3", ex_result);
      else passed++;
      stall = 1'b1; flush = 1'b1; tick();
      total++;
      if (obs() !== BUBBLE) $display("FAIL flush_over_stall got %h exp %h", obs(), BUBBLE);
      else passed++;
      stall = 1'b0; flush = 1'b0;
   endtask

   task automatic test_back_to_back();
      alu(ALUOP_ADD, 32'd100, 32'd1, 5'd10); tick();
      total++;
      if (ex_result !== 32'd101) $display("FAIL b2b_first got %h exp 101", ex_result);
      else passed++;
      alu(ALUOP_SUB, 32'd100, 32'd1, 5'd11); tick();
      total++;
      if (obs() !== ex(1, 32'd99, 5'd11, 1, 0, 0, 0))
         $display("FAIL b2b_second got %h exp %h", obs(), ex(1, 32'd99, 5'd11, 1, 0, 0, 0));
      else passed++;
   endtask

   task automatic test_reset_mid();
      alu(ALUOP_ADD, 32'd4, 32'd4, 5'd12); tick();
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (obs() !== BUBBLE) $display("FAIL async_reset got %h exp %h", obs(), BUBBLE);
      else passed++;
      #4 rst_n = 1'b1;   // released before the next rising edge
      alu(ALUOP_ADD, 32'd1, 32'd1, 5'd1); tick();
      total++;
      if (obs() !== ex(1, 32'd2, 5'd1, 1, 0, 0, 0))
         $display("FAIL add_after_reset got %h exp %h", obs(), ex(1, 32'd2, 5'd1, 1, 0, 0, 0));
      else passed++;

      // a pending squash from a jump is discarded by reset
      drive(1'b1, ALUOP_ADD, 32'd0, 32'd0, 32'h500, 32'h8, 5'd1, 1'b1, 2, 1'b0); tick();
      #2 rst_n = 1'b0;
      #5 rst_n = 1'b1;
      alu(ALUOP_ADD, 32'd20, 32'd22, 5'd4); tick();
      total++;
      if (obs() !== ex(1, 32'd42, 5'd4, 1, 0, 0, 0))
         $display("FAIL squash_cleared_by_reset got %h exp %h", obs(), ex(1, 32'd42, 5'd4, 1, 0, 0, 0));
      else passed++;
   endtask

   initial begin
      test_reset();
      test_alu();
      test_branch_squash();
      test_jumps();
      test_stall_flush();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout got running exp finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock; rst_n  input  1  asynchronous active-low reset.
REQ-002 id_valid  input  1  instruction present from decode.
REQ-003 id_alucontrol  input  4  ALU operation from the ALU decoder, encoded with the team's ALUOP_* constants.
REQ-004 id_inv_branch  input  1  invert branch condition (bne, bge, bgeu).
REQ-005 id_is_branch / id_is_jal / id_is_jalr  input  1 each  instruction class, mutually exclusive.
REQ-006 id_src_a, id_src_b  input  32  ALU operands, already forwarded and muxed.
REQ-007 id_pc, id_imm  input  32  instruction PC and sign-extended immediate.
REQ-008 id_rd  input  5; id_reg_write  input  1  destination and write enable.
REQ-009 stall  input  1  hold stage; flush  input  1  insert bubble.
REQ-010 ex_valid  output  1; ex_result  output  32; ex_rd  output  5; ex_reg_write  output  1; ex_branch_taken  output  1; ex_branch_target  output  32; ex_illegal_op  output  1. All are registered.

Function
REQ-011 Latency SHALL be one cycle: operands sampled at edge N SHALL appear on the ex_* outputs from edge N onward.
REQ-012 ALU ops: ADD a+b, SUB a-b (mod 2^32), SLL a<<b[4:0], SRL logical, SRA arithmetic, SLT signed a<b -> 1 else 0, SLTU unsigned a<b -> 1 else 0, XOR/OR/AND bitwise.
REQ-013 An unlisted alucontrol with id_valid=1 SHALL load ex_result=0 and ex_illegal_op=1, with ex_reg_write=0.
REQ-014 Branch: taken = (SUB ? (a-b)==0 : result[0]) XOR id_inv_branch; target = id_pc+id_imm; ex_result=0; ex_reg_write=0.
REQ-015 JAL: taken=1, target=id_pc+id_imm, ex_result=id_pc+4.
REQ-016 JALR: taken=1, target=(id_src_a+id_imm) with bit0 cleared, ex_result=id_pc+4.
REQ-017 Non-branch, non-jump: ex_branch_taken=0, ex_branch_target=0.
REQ-018 All additions SHALL wrap modulo 2^32 and SHALL NOT flag overflow.
REQ-019 A bubble SHALL be ex_valid=0, ex_reg_write=0, ex_branch_taken=0, ex_illegal_op=0, ex_result=0, ex_branch_target=0, ex_rd=0.
REQ-020 id_valid=0 SHALL load a bubble.
REQ-021 stall=1 with flush=0 SHALL hold every output register unchanged.
REQ-022 flush=1 SHALL load a bubble regardless of stall; flush has priority.
REQ-023 Shadow squash: if ex_valid=1 and ex_branch_taken=1 during a cycle and stall=0, the next edge SHALL load a bubble regardless of id_valid (wrong-path kill).
REQ-024 Shadow squash is one-shot: after the bubble loads, taken=0, so the following cycle accepts input normally.
REQ-025 With stall=1 and ex_branch_taken=1, the taken branch SHALL hold; the squash SHALL occur at the first edge with stall=0.
REQ-026 ex_rd=0 with id_reg_write=1 SHALL pass through unchanged; x0 suppression belongs to writeback.

Reset
REQ-027 rst_n low SHALL immediately force every output to the bubble values of REQ-019, independent of clk.
REQ-028 Reset mid-operation SHALL discard the in-flight instruction and any pending squash; the first edge after rst_n rises SHALL accept id_* normally.

Verification
REQ-029 ADD a=5 b=7 rd=3 -> next cycle ex_valid=1, ex_result=12, ex_rd=3, ex_reg_write=1; SUB 3-5 -> 0xFFFFFFFE.
REQ-030 SRA a=0x80000000 b=4 -> 0xF8000000; SRL same operands -> 0x08000000; SLT a=0xFFFFFFFF b=1 -> 1; SLTU same -> 0.
REQ-031 BNE SUB inv=1 pc=0x100 imm=0x10: a=3 b=3 -> taken=0; a=3 b=4 -> taken=1, target=0x110, and the following id_valid=1 ADD is squashed (ex_valid=0).
REQ-032 JALR a=0x1001 imm=4 pc=0x200 -> taken=1, target=0x1004, ex_result=0x204.
REQ-033 Taken branch loaded, then stall=1 for 2 cycles -> outputs held; stall drops -> bubble; stall=1 with flush=1 -> bubble.
REQ-034 rst_n pulsed low mid-cycle while ex_valid=1 -> outputs zero immediately; after release, ADD 1+1 -> ex_result=2.
